sar_adc_ctrl: RTL and testbench

Successive-approximation ADC controller: the read-back end of the BabySoC analog path. Where the core drives 10-bit codes into the DAC, this block drives trial codes into a DAC and reads a 1-bit comparator. It resolves an analog input into a WIDTH-bit digital result with a binary search. The result is presented to the core with a valid/ready handshake. Single-shot and continuous conversion modes are supported.

---
 rtl/sar_adc_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
// Sequences the track/hold switch and the DAC trial codes, reads a 1-bit
// comparator and resolves a WIDTH-bit code by binary search. Completed
// results are held behind a valid/ready handshake with a sticky overrun
// flag. Supports single-shot and continuous conversion.
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             comp,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  // Bit-index width and shared SAMPLE/SETTLE counter width.
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]    MSB_IDX     = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_DECIDE,
    S_FINISH
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    bit_q;
  logic [WIDTH-1:0] code_q;
  logic             sample_q;
  logic [WIDTH-1:0] dac_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             ovr_q;

  logic [WIDTH-1:0] code_d;
  logic             load_d;

  // Code after the current DECIDE: drop the trial bit on comp=0 and
  // raise the next lower bit as the following trial.
  always_comb begin
    code_d = code_q;
    if (!comp) begin
      code_d[bit_q] = 1'b0;
    end
    if (bit_q != '0) begin
      code_d[bit_q - 1'b1] = 1'b1;
    end
  end

  // A new result is produced at the closing edge of the last DECIDE.
  assign load_d = (state_q == S_DECIDE) && (bit_q == '0);

  // Conversion sequencer with registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      sample_q <= 1'b0;
      dac_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_SAMPLE;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
            dac_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            state_q  <= S_SETTLE;
            sample_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= MSB_IDX;
            code_q   <= MSB_CODE;
            dac_q    <= MSB_CODE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_DECIDE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DECIDE: begin
          code_q <= code_d;
          if (bit_q != '0) begin
            bit_q   <= bit_q - 1'b1;
            state_q <= S_SETTLE;
            dac_q   <= code_d;
          end else begin
            state_q <= S_FINISH;
            dac_q   <= '0;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          cnt_q <= '0;
          if (cont) begin
            state_q  <= S_SAMPLE;
            sample_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          sample_q <= 1'b0;
          dac_q    <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Result holding register, valid/ready handshake and sticky overrun.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (load_d) begin
        result_q <= code_d;
        valid_q  <= 1'b1;
      end else if (valid_q && res_ready) begin
        valid_q <= 1'b0;
      end
      // Overwriting unread data sets the flag; setting beats clearing.
      if (load_d && valid_q && !res_ready) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign sample    = sample_q;
  assign dac_code  = dac_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign res_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with a comparator model and a result
// scoreboard: expected codes are queued at start and checked on done.
module tb_sar_adc_ctrl;

  localparam int W  = 10;
  localparam int SC = 4;
  localparam int ST = 2;
  localparam int DONE_EDGE = SC + W * (ST + 1);

  logic         CLK = 1'b0;
  logic         reset, start, cont, comp, res_ready, ovr_clr;
  logic         sample, busy, done, res_valid, overrun;
  logic [W-1:0] dac_code, result;

  int x_val = 0;
  int checks = 0;
  int failures = 0;
  int e = 0;
  int ndone = 0;
  int done_edge = -1;
  int exp_q[$];
  int codes[W];

  always #5 CLK = ~CLK;

  // Comparator: 1 when the analog input is at or above the DAC output.
  assign comp = (x_val >= int'(dac_code));

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .CLK(CLK), .reset(reset), .start(start), .cont(cont), .comp(comp),
    .sample(sample), .dac_code(dac_code), .busy(busy), .done(done),
    .result(result), .res_valid(res_valid), .res_ready(res_ready),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance one edge, sample 1 time unit later; score any completed result.
  task automatic tick;
    int ex;
    @(posedge CLK);
    #1;
    e++;
    if (done) begin
      ndone++;
      done_edge = e;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        ex = exp_q.pop_front();
        chk("sb_result", result, ex);
        chk("sb_res_valid", res_valid, 1);
      end
      $display("conversion done edge=%0d result=%0d overrun=%0d", e, result, overrun);
    end
  endtask

  // Reference binary search: trial code presented in each DECIDE cycle.
  task automatic build_codes(input int x);
    int c;
    c = 1 << (W - 1);
    for (int b = W - 1; b >= 0; b--) begin
      codes[W-1-b] = c;
      if (x < c) c = c & ~(1 << b);
      if (b > 0) c = c | (1 << (b - 1));
    end
  endtask

  task automatic start_conv(input int x);
    x_val = x;
    exp_q.push_back(x);
    start = 1'b1;
    e = -1;
    tick;
    start = 1'b0;
    chk("start_sample", sample, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic run_to_done(input bit chk_codes);
    int idx;
    int nd0;
    idx = 0;
    nd0 = ndone;
    done_edge = -1;
    while (ndone == nd0 && e < 200) begin
      tick;
      if (e == SC - 1) chk("sample_last_high", sample, 1);
      if (e == SC) chk("sample_low", sample, 0);
      if (chk_codes && e >= SC + ST && ((e - SC - ST) % (ST + 1)) == 0 && idx < W) begin
        chk($sformatf("dac_trial%0d", idx), dac_code, codes[idx]);
        idx++;
      end
    end
    chk("done_edge", done_edge, DONE_EDGE);
  endtask

  task automatic consume;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("consume_valid", res_valid, 0);
  endtask

  initial begin
    int nd0;
    reset = 1'b1; start = 1'b0; cont = 1'b0; res_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sample", sample, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick;

    // Single shot X=677 with the published trial sequence.
    codes = '{512, 768, 640, 704, 672, 688, 680, 676, 678, 677};
    start_conv(677);
    run_to_done(1'b1);
    chk("s677_done_busy", busy, 1);
    tick;
    chk("s677_busy_after", busy, 0);
    chk("s677_done_pulse", done, 0);
    chk("s677_hold", result, 677);
    consume;

    // Extremes.
    build_codes(0);
    start_conv(0);
    run_to_done(1'b1);
    tick;
    consume;
    build_codes(1023);
    start_conv(1023);
    run_to_done(1'b1);
    tick;
    consume;

    // Continuous mode, consumer stalled: second result overruns.
    cont = 1'b1;
    start_conv(100);
    run_to_done(1'b0);
    chk("cont_ovr_first", overrun, 0);
    x_val = 200;
    exp_q.push_back(200);
    tick;
    chk("cont_restart_busy", busy, 1);
    chk("cont_restart_sample", sample, 1);
    cont = 1'b0;
    e = 0;
    run_to_done(1'b0);
    chk("cont_overrun", overrun, 1);
    chk("cont_valid", res_valid, 1);
    tick;
    chk("cont_idle", busy, 0);
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_clr_keeps_valid", res_valid, 1);
    consume;

    // Coincident transfer and load; start while busy is ignored.
    start_conv(300);
    run_to_done(1'b0);
    tick;
    nd0 = ndone;
    start_conv(400);
    while (e < 80) begin
      tick;
      if (e == 10) start = 1'b1;
      if (e == 11) start = 1'b0;
      if (e == 33) res_ready = 1'b1;
      if (e == 34) begin
        res_ready = 1'b0;
        chk("coinc_valid", res_valid, 1);
        chk("coinc_overrun", overrun, 0);
      end
    end
    chk("coinc_done_edge", done_edge, DONE_EDGE);
    chk("single_done_count", ndone - nd0, 1);
    chk("coinc_idle", busy, 0);
    consume;

    // Asynchronous reset mid-conversion, then a fresh conversion.
    start_conv(500);
    while (e < 15) tick;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sample", sample, 0);
    chk("arst_dac", dac_code, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_overrun", overrun, 0);
    exp_q.delete();
    tick;
    reset = 1'b0;
    tick;
    build_codes(341);
    start_conv(341);
    run_to_done(1'b1);
    tick;
    consume;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
